// File: rtl/serial_byte_packer.sv
// Serial-to-parallel frame assembler with optional even parity and a single-entry
// valid/ready output slot; flags dropped bytes (overrun) and discarded partial frames.
module serial_byte_packer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sin_valid,
  input  logic             sin_data,
  input  logic             sin_start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_perr,
  output logic             overrun,
  output logic             frame_abort
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shifted_c;
  logic [WIDTH-1:0] byte_c;
  logic             done_c, abort_c, perr_c;

  logic [WIDTH-1:0] out_data_d;
  logic             out_valid_d, out_perr_d, overrun_d, frame_abort_d;

  assign shifted_c = {shreg_q[WIDTH-2:0], sin_data};

  // Frame state, bit counter and shift register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state: a start bit always opens a new frame, taking priority over completion
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    byte_c  = shreg_q;
    done_c  = 1'b0;
    abort_c = 1'b0;
    perr_c  = 1'b0;
    if (sin_valid) begin
      if (sin_start) begin
        abort_c = (state_q == SHIFT) || (state_q == PAR);
        shreg_d = WIDTH'(sin_data);
        cnt_d   = CW'(1);
        state_d = SHIFT;
      end else begin
        case (state_q)
          SHIFT: begin
            shreg_d = shifted_c;
            if (cnt_q == CW'(WIDTH - 1)) begin
              if (PARITY_EN) begin
                cnt_d   = CW'(WIDTH);
                state_d = PAR;
              end else begin
                done_c  = 1'b1;
                byte_c  = shifted_c;
                cnt_d   = '0;
                state_d = IDLE;
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          PAR: begin
            done_c  = 1'b1;
            byte_c  = shreg_q;
            perr_c  = ^{shreg_q, sin_data};
            cnt_d   = '0;
            state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Slot update: load when free, otherwise drop the byte and flag overrun
  always_comb begin
    out_data_d    = out_data;
    out_valid_d   = out_valid;
    out_perr_d    = out_perr;
    overrun_d     = 1'b0;
    frame_abort_d = abort_c;
    if (done_c) begin
      if (!out_valid || out_ready) begin
        out_data_d  = byte_c;
        out_perr_d  = perr_c;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_perr    <= 1'b0;
      overrun     <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      out_data    <= out_data_d;
      out_valid   <= out_valid_d;
      out_perr    <= out_perr_d;
      overrun     <= overrun_d;
      frame_abort <= frame_abort_d;
    end
  end

endmodule

// File: tb/tb_serial_byte_packer.sv
// Directed bench for serial_byte_packer (WIDTH=8, PARITY_EN=1).
module tb_serial_byte_packer;

  logic       clk;
  logic       reset_n;
  logic       sin_valid;
  logic       sin_data;
  logic       sin_start;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_perr;
  logic       overrun;
  logic       frame_abort;

  int errors;
  int checks;

  serial_byte_packer #(.WIDTH(8), .PARITY_EN(1'b1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sin_valid   (sin_valid),
    .sin_data    (sin_data),
    .sin_start   (sin_start),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_perr    (out_perr),
    .overrun     (overrun),
    .frame_abort (frame_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one accepted bit; returns 1 time unit after the sampling edge
  task automatic send_bit(input logic s, input logic d);
    @(negedge clk);
    sin_valid = 1'b1;
    sin_start = s;
    sin_data  = d;
    @(posedge clk);
    #1;
    sin_valid = 1'b0;
    sin_start = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    sin_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_rest(input logic [7:0] b);
    for (int i = 6; i >= 0; i--) send_bit(1'b0, b[i]);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p);
    send_bit(1'b1, b[7]);
    send_rest(b);
    send_bit(1'b0, p);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    // Comparisons are done inline in each test
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sin_valid = 1'b0; sin_data = 1'b0; sin_start = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    #1;
    checks++;
    if ({out_data, out_valid, out_perr, overrun, frame_abort} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 000", {out_data, out_valid, out_perr, overrun, frame_abort});
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_frame(8'hA5, 1'b0);
    checks++;
    if ({out_valid, out_data, out_perr} !== {1'b1, 8'hA5, 1'b0}) begin
      errors++;
      $display("FAIL basic_a5: got v=%b d=%h p=%b expected v=1 d=a5 p=0", out_valid, out_data, out_perr);
    end
    idle_cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: got v=%b expected 0", out_valid);
    end
  endtask

  task automatic test_parity();
    send_frame(8'h3C, 1'b1);
    checks++;
    if ({out_valid, out_data, out_perr} !== {1'b1, 8'h3C, 1'b1}) begin
      errors++;
      $display("FAIL parity_3c: got v=%b d=%h p=%b expected v=1 d=3c p=1", out_valid, out_data, out_perr);
    end
    idle_cycle();
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    send_frame(8'h11, 1'b0);
    checks++;
    if ({out_valid, out_data} !== {1'b1, 8'h11}) begin
      errors++;
      $display("FAIL ovr_first: got v=%b d=%h expected v=1 d=11", out_valid, out_data);
    end
    send_frame(8'h22, 1'b0);
    checks++;
    if ({out_valid, out_data, overrun} !== {1'b1, 8'h11, 1'b1}) begin
      errors++;
      $display("FAIL ovr_pulse: got v=%b d=%h ovr=%b expected v=1 d=11 ovr=1", out_valid, out_data, overrun);
    end
    idle_cycle();
    checks++;
    if ({out_valid, out_data, overrun} !== {1'b1, 8'h11, 1'b0}) begin
      errors++;
      $display("FAIL ovr_hold: got v=%b d=%h ovr=%b expected v=1 d=11 ovr=0", out_valid, out_data, overrun);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovr_drain: got v=%b expected 0", out_valid);
    end
    // Same pair, but the consumer accepts on the completion edge of the second byte
    out_ready = 1'b0;
    send_frame(8'h11, 1'b0);
    send_bit(1'b1, 1'b0);
    send_rest(8'h22);
    out_ready = 1'b1;
    send_bit(1'b0, 1'b0);
    checks++;
    if ({out_valid, out_data, overrun} !== {1'b1, 8'h22, 1'b0}) begin
      errors++;
      $display("FAIL reload: got v=%b d=%h ovr=%b expected v=1 d=22 ovr=0", out_valid, out_data, overrun);
    end
    idle_cycle();
  endtask

  task automatic test_abort();
    out_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    repeat (3) send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    checks++;
    if ({frame_abort, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL abort_pulse: got abort=%b v=%b expected abort=1 v=0", frame_abort, out_valid);
    end
    send_rest(8'h7E);
    send_bit(1'b0, 1'b0);
    checks++;
    if ({out_valid, out_data, out_perr, frame_abort} !== {1'b1, 8'h7E, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_7e: got v=%b d=%h p=%b abort=%b expected v=1 d=7e p=0 abort=0",
               out_valid, out_data, out_perr, frame_abort);
    end
    idle_cycle();
    // Start bit landing on the parity slot aborts instead of completing
    send_bit(1'b1, 1'b1);
    send_rest(8'hFF);
    send_bit(1'b1, 1'b1);
    checks++;
    if ({frame_abort, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL abort_par: got abort=%b v=%b expected abort=1 v=0", frame_abort, out_valid);
    end
    send_rest(8'h81);
    send_bit(1'b0, 1'b0);
    checks++;
    if ({out_valid, out_data, out_perr} !== {1'b1, 8'h81, 1'b0}) begin
      errors++;
      $display("FAIL abort_par_81: got v=%b d=%h p=%b expected v=1 d=81 p=0", out_valid, out_data, out_perr);
    end
    idle_cycle();
  endtask

  task automatic test_gaps();
    logic [7:0] b;
    b = 8'hC3;
    repeat (3) send_bit(1'b0, 1'b1);
    checks++;
    if ({out_valid, overrun, frame_abort} !== 3'b000) begin
      errors++;
      $display("FAIL stray_bits: got v=%b ovr=%b abort=%b expected 000", out_valid, overrun, frame_abort);
    end
    send_bit(1'b1, b[7]);
    idle_cycle();
    for (int i = 6; i >= 0; i--) begin
      send_bit(1'b0, b[i]);
      if (i % 2 == 1) idle_cycle();
    end
    idle_cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL gap_hold: got v=%b expected 0", out_valid);
    end
    send_bit(1'b0, 1'b0);
    checks++;
    if ({out_valid, out_data, out_perr} !== {1'b1, 8'hC3, 1'b0}) begin
      errors++;
      $display("FAIL gaps_c3: got v=%b d=%h p=%b expected v=1 d=c3 p=0", out_valid, out_data, out_perr);
    end
    idle_cycle();
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    send_frame(8'h5A, 1'b0);
    send_bit(1'b1, 1'b1);
    repeat (4) send_bit(1'b0, 1'b0);
    checks++;
    if ({out_valid, out_data} !== {1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL pre_reset: got v=%b d=%h expected v=1 d=5a", out_valid, out_data);
    end
    @(negedge clk); reset_n = 1'b0;
    #1;
    checks++;
    if ({out_data, out_valid, out_perr, overrun, frame_abort} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: got %h expected 000", {out_data, out_valid, out_perr, overrun, frame_abort});
    end
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1; out_ready = 1'b1;
    repeat (3) send_bit(1'b0, 1'b1);
    send_frame(8'h96, 1'b1);
    checks++;
    if ({out_valid, out_data, out_perr, frame_abort} !== {1'b1, 8'h96, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_96: got v=%b d=%h p=%b abort=%b expected v=1 d=96 p=1 abort=0",
               out_valid, out_data, out_perr, frame_abort);
    end
    idle_cycle();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_parity();
    test_overrun();
    test_abort();
    test_gaps();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
